// File: rtl/ac_sweep_stimulus_pkg.sv
// Shared types and constants for the AC sweep stimulus: FSM states,
// quadrant decode bits and the sine peak amplitude.
package ac_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_NEXT,
    ST_FIN
  } stim_state_e;

  // Bits of the 2-bit quadrant field taken from the phase MSBs.
  localparam int unsigned QUAD_MIRROR_BIT = 0;
  localparam int unsigned QUAD_NEG_BIT    = 1;

  // Symmetric peak so negation never overflows the signed sample width.
  function automatic int unsigned lut_amp(input int unsigned sample_w);
    return (32'd1 << (sample_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/ac_sweep_stimulus_if.sv
// Sample stream from the sweep source to the DAC/port model.
interface ac_sweep_stimulus_if #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned NPTS_W   = 8
);
  logic signed [SAMPLE_W-1:0] smp_data;
  logic                       smp_valid;
  logic                       smp_ready;
  logic [NPTS_W-1:0]          point_idx;
  logic                       point_first;

  modport master (output smp_data, output smp_valid, output point_idx,
                  output point_first, input smp_ready);
  modport slave  (input smp_data, input smp_valid, input point_idx,
                  input point_first, output smp_ready);
endinterface

// File: rtl/ac_sweep_stimulus_lut.sv
// Quarter-wave sine ROM, one-cycle registered read; entry k = peak*sin(pi/2*k/2^AW).
module sine_quarter_lut
  import ac_stim_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data_q
);

  function automatic logic [DW-1:0] sine_entry(input int k);
    real amp;
    real ang;
    amp = real'(lut_amp(DW + 1));
    ang = 3.14159265358979 / 2.0 * real'(k) / real'(2 ** AW);
    return DW'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [DW-1:0] rom [2**AW];

  for (genvar k = 0; k < 2**AW; k++) begin : g_rom
    assign rom[k] = sine_entry(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= rom[addr];
  end

endmodule

// File: rtl/ac_sweep_stimulus.sv
// Stepped-frequency sine sweep source: NCO + quarter-wave LUT, per-point dwell,
// valid/ready sample stream.
module ac_sweep_stimulus
  import ac_stim_pkg::*;
#(
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned LUT_AW   = 8,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned NPTS_W   = 8,
  parameter int unsigned DWELL_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PHASE_W-1:0]  f_start,
  input  logic [PHASE_W-1:0]  f_step,
  input  logic [NPTS_W-1:0]   n_points,
  input  logic [DWELL_W-1:0]  dwell,
  ac_sweep_stimulus_if.master smp,
  output logic                busy,
  output logic                done
);

  localparam logic [SAMPLE_W-1:0] AMP = SAMPLE_W'(lut_amp(SAMPLE_W));

  stim_state_e          state_q;
  logic [PHASE_W-1:0]   phase_q, phase_d, ftw_q, step_q;
  logic [NPTS_W-1:0]    npts_m1_q, idx_q;
  logic [DWELL_W-1:0]   dwell_m1_q, dwell_cnt_q;
  logic                 valid_q, first_q, busy_q, done_q;
  logic                 neg_q, peak_q;
  logic [SAMPLE_W-2:0]  lut_q;
  logic [1:0]           quad_d;
  logic [LUT_AW-1:0]    frac_d, addr_d;
  logic [SAMPLE_W-1:0]  mag;
  logic                 accept, start_ok;

  assign accept   = valid_q & smp.smp_ready;
  assign start_ok = (state_q == ST_IDLE) & start & ~abort;

  always_comb begin
    phase_d = phase_q;
    if (start_ok)    phase_d = '0;
    else if (accept) phase_d = phase_q + ftw_q;
  end

  // The LUT always reads the phase that will be current next cycle, so the
  // registered word tracks phase_q and the next sample is ready on accept.
  assign quad_d = phase_d[PHASE_W-1 -: 2];
  assign frac_d = phase_d[PHASE_W-3 -: LUT_AW];
  assign addr_d = quad_d[QUAD_MIRROR_BIT] ? ('0 - frac_d) : frac_d;

  sine_quarter_lut #(
    .AW(LUT_AW),
    .DW(SAMPLE_W - 1)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_d),
    .data_q(lut_q)
  );

  // Mirrored offset 0 would need entry 2^LUT_AW (the peak), which the ROM lacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q  <= 1'b0;
      peak_q <= 1'b0;
    end else begin
      neg_q  <= quad_d[QUAD_NEG_BIT];
      peak_q <= quad_d[QUAD_MIRROR_BIT] & (frac_d == '0);
    end
  end

  assign mag = peak_q ? AMP : {1'b0, lut_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      ftw_q       <= '0;
      step_q      <= '0;
      npts_m1_q   <= '0;
      dwell_m1_q  <= '0;
      idx_q       <= '0;
      dwell_cnt_q <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      phase_q <= phase_d;
      done_q  <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        first_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_ok) begin
            ftw_q       <= f_start;
            step_q      <= f_step;
            npts_m1_q   <= (n_points == '0) ? '0 : n_points - NPTS_W'(1);
            dwell_m1_q  <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_LOAD;
          end
          ST_LOAD: begin
            valid_q <= 1'b1;
            first_q <= 1'b1;
            state_q <= ST_RUN;
          end
          ST_RUN: if (accept) begin
            first_q <= 1'b0;
            if (dwell_cnt_q == dwell_m1_q) begin
              valid_q     <= 1'b0;
              dwell_cnt_q <= '0;
              if (idx_q == npts_m1_q) begin
                done_q  <= 1'b1;
                state_q <= ST_FIN;
              end else begin
                state_q <= ST_NEXT;
              end
            end else begin
              dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
            end
          end
          ST_NEXT: begin
            ftw_q   <= ftw_q + step_q;
            idx_q   <= idx_q + NPTS_W'(1);
            valid_q <= 1'b1;
            first_q <= 1'b1;
            state_q <= ST_RUN;
          end
          ST_FIN: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign smp.smp_data    = neg_q ? ('0 - mag) : mag;
  assign smp.smp_valid   = valid_q;
  assign smp.point_idx   = idx_q;
  assign smp.point_first = first_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_ac_sweep_stimulus.sv
// Directed bench for ac_sweep_stimulus with hand-computed sine sample tables.
module tb_ac_sweep_stimulus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] f_start = '0;
  logic [23:0] f_step = '0;
  logic [7:0]  n_points = '0;
  logic [15:0] dwell = '0;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  int exp_data[$];
  int exp_idx[$];
  bit exp_first[$];

  ac_sweep_stimulus_if #(.SAMPLE_W(12), .NPTS_W(8)) smp_if ();

  ac_sweep_stimulus #(
    .PHASE_W (24),
    .LUT_AW  (8),
    .SAMPLE_W(12),
    .NPTS_W  (8),
    .DWELL_W (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .f_start (f_start),
    .f_step  (f_step),
    .n_points(n_points),
    .dwell   (dwell),
    .smp     (smp_if),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // 1 unit = 2^20 of phase = 1/16 period: sin(k*22.5 deg)*2047 rounded.
  task automatic load_basic();
    exp_data  = '{0, 783, 1447, 1891, 2047, 1447, 0, -1447, -2047, -783, 1447, 1891};
    exp_idx   = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    exp_first = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
  endtask

  task automatic run_sweep(input string name, input logic [23:0] fs, input logic [23:0] fst,
                           input logic [7:0] np, input logic [15:0] dw, input int duty,
                           input int exp_done_cyc, input int poke_cyc);
    int n, last_acc;
    bit fin, prev_stall;
    logic signed [11:0] prev_data;
    n = 0; last_acc = -10; fin = 0; prev_stall = 0; prev_data = '0;
    f_start = fs; f_step = fst; n_points = np; dwell = dw;
    smp_if.smp_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        f_start = 24'h5A5A5A; n_points = 8'd9; dwell = 16'd1;
      end
      if (cyc == 0) begin
        checks++;
        if (smp_if.smp_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s load_cycle: valid=%b busy=%b, required valid=0 busy=1", name, smp_if.smp_valid, busy);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (smp_if.smp_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s first_latency: valid=%b, required 1", name, smp_if.smp_valid);
        end
      end
      if (prev_stall) begin
        checks++;
        if (smp_if.smp_valid !== 1'b1 || smp_if.smp_data !== prev_data) begin
          errors++;
          $display("FAIL %s stall_hold cyc %0d: valid=%b data=%0d, required valid=1 data=%0d",
                   name, cyc, smp_if.smp_valid, smp_if.smp_data, prev_data);
        end
      end
      if (done === 1'b1) begin
        fin = 1;
        checks++;
        if (cyc != last_acc + 1) begin
          errors++;
          $display("FAIL %s done_timing: done at cyc %0d, required %0d", name, cyc, last_acc + 1);
        end
        if (exp_done_cyc >= 0) begin
          checks++;
          if (cyc != exp_done_cyc) begin
            errors++;
            $display("FAIL %s throughput: done at cyc %0d, required %0d", name, cyc, exp_done_cyc);
          end
        end
      end
      smp_if.smp_ready = ($urandom_range(0, 99) < duty);
      if (smp_if.smp_valid === 1'b1 && smp_if.smp_ready) begin
        checks++;
        if (n >= exp_data.size()) begin
          errors++;
          $display("FAIL %s extra_sample %0d: data=%0d, required no sample", name, n, smp_if.smp_data);
        end else if (int'(smp_if.smp_data) !== exp_data[n] || int'(smp_if.point_idx) !== exp_idx[n] ||
                     smp_if.point_first !== exp_first[n]) begin
          errors++;
          $display("FAIL %s sample %0d: data=%0d idx=%0d first=%b, required data=%0d idx=%0d first=%b",
                   name, n, smp_if.smp_data, smp_if.point_idx, smp_if.point_first,
                   exp_data[n], exp_idx[n], exp_first[n]);
        end
        n++;
        last_acc = cyc;
      end
      prev_stall = (smp_if.smp_valid === 1'b1) && !smp_if.smp_ready;
      prev_data  = smp_if.smp_data;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s done_timeout: done=0, required a done pulse", name);
    end
    checks++;
    if (n != exp_data.size()) begin
      errors++;
      $display("FAIL %s sample_count: got %0d, required %0d", name, n, exp_data.size());
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || smp_if.smp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b valid=%b, required 0 0 0",
               name, done, busy, smp_if.smp_valid);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (smp_if.smp_valid !== 1'b0 || smp_if.smp_data !== 12'sd0 || busy !== 1'b0 || done !== 1'b0 ||
        smp_if.point_idx !== 8'd0 || smp_if.point_first !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d busy=%b done=%b idx=%0d first=%b, required all 0",
               smp_if.smp_valid, smp_if.smp_data, busy, done, smp_if.point_idx, smp_if.point_first);
    end
    rst_n = 1'b1;
    f_start = 24'h100000; f_step = 24'h100000; n_points = 8'd3; dwell = 16'd4;
    smp_if.smp_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (smp_if.smp_valid !== 1'b0 || smp_if.smp_data !== 12'sd0 || busy !== 1'b0 || done !== 1'b0 ||
        smp_if.point_idx !== 8'd0 || smp_if.point_first !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: valid=%b data=%0d busy=%b done=%b idx=%0d first=%b, required all 0",
               smp_if.smp_valid, smp_if.smp_data, busy, done, smp_if.point_idx, smp_if.point_first);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (smp_if.smp_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet cyc %0d: valid=%b busy=%b done=%b, required 0 0 0",
                 i, smp_if.smp_valid, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    load_basic();
    run_sweep("basic", 24'h100000, 24'h100000, 8'd3, 16'd4, 100, 15, -1);
  endtask

  task automatic test_quadrant();
    exp_data  = '{0, 2047, 0, -2047, 0, 2047, 0, -2047};
    exp_idx   = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_first = '{1, 0, 0, 0, 0, 0, 0, 0};
    run_sweep("quadrant", 24'h400000, 24'h000000, 8'd1, 16'd8, 100, 9, -1);
  endtask

  task automatic test_backpressure();
    load_basic();
    run_sweep("backpressure", 24'h100000, 24'h100000, 8'd3, 16'd4, 30, -1, -1);
  endtask

  task automatic test_wrap();
    // Point 0 ftw = 15 units, point 1 ftw wraps to 1 unit: phases 0,15,14 | 13,14,15.
    exp_data  = '{0, -783, -1447, -1891, -1447, -783};
    exp_idx   = '{0, 0, 0, 1, 1, 1};
    exp_first = '{1, 0, 0, 1, 0, 0};
    run_sweep("wrap", 24'hF00000, 24'h200000, 8'd2, 16'd3, 100, 8, -1);
  endtask

  task automatic test_degenerate();
    exp_data  = '{0};
    exp_idx   = '{0};
    exp_first = '{1};
    run_sweep("degenerate", 24'h100000, 24'h100000, 8'd0, 16'd0, 100, 2, -1);
  endtask

  task automatic test_abort_race();
    bit got;
    int seen;
    got = 0; seen = 0;
    f_start = 24'h100000; f_step = 24'h100000; n_points = 8'd3; dwell = 16'd4;
    smp_if.smp_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      if (smp_if.smp_valid === 1'b1 && smp_if.point_idx === 8'd1) begin
        abort = 1'b1;
        got = 1;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL abort_reach_point1: never saw point 1, required within 40 cycles");
    end
    checks++;
    if (smp_if.smp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: valid=%b busy=%b, required 0 0", smp_if.smp_valid, busy);
    end
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", seen);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || smp_if.smp_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort: busy=%b valid=%b, required 0 0", busy, smp_if.smp_valid);
    end
    // A fresh sweep after abort must restart from phase 0.
    exp_data  = '{0};
    exp_idx   = '{0};
    exp_first = '{1};
    run_sweep("after_abort", 24'h100000, 24'h100000, 8'd1, 16'd1, 100, 2, -1);
  endtask

  task automatic test_start_busy();
    load_basic();
    run_sweep("start_busy", 24'h100000, 24'h100000, 8'd3, 16'd4, 100, 15, 3);
  endtask

  initial begin
    smp_if.smp_ready = 1'b0;
    test_reset();
    test_basic();
    test_quadrant();
    test_backpressure();
    test_wrap();
    test_degenerate();
    test_abort_race();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
